// File: rtl/stream_sat_accumulator.sv
// stream_sat_accumulator: sums a streamed group of signed operands at full precision
// and emits one saturated or wrapped result per group with overflow flag and count.
module stream_sat_accumulator #(
    parameter int WIDTH = 8,
    parameter int NUM_OPERANDS = 5,
    localparam int ACC_W = WIDTH + $clog2(NUM_OPERANDS) + 1,
    localparam int CNT_W = $clog2(NUM_OPERANDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sat_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ACCUM, OUTPUT} state_t;
    state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, tot, max_a, min_a;
    logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d, max_w, min_w;
    logic out_valid_q, out_valid_d, ovf_q, ovf_d, accept, final_beat, hi, lo;
    assign max_w = {1'b0, {(WIDTH-1){1'b1}}};
    assign min_w = {1'b1, {(WIDTH-1){1'b0}}};
    assign max_a = {{(ACC_W-WIDTH){1'b0}}, max_w};
    assign min_a = {{(ACC_W-WIDTH){1'b1}}, min_w};
    assign in_ready = (state_q == ACCUM) && !reset;
    assign accept = in_valid && in_ready;
    assign final_beat = in_last || (cnt_q + 1'b1 == CNT_W'(NUM_OPERANDS));
    assign tot = acc_q + {{(ACC_W-WIDTH){in_data[WIDTH-1]}}, in_data};
    assign hi = tot > max_a;
    assign lo = tot < min_a;
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_valid_d = out_valid_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        count_d = count_q;
        if (accept && final_beat) begin
            state_d = OUTPUT;
            acc_d = '0;
            cnt_d = '0;
            out_valid_d = 1'b1;
            sum_d = !sat_en ? tot[WIDTH-1:0] : hi ? max_w : lo ? min_w : tot[WIDTH-1:0];
            ovf_d = hi || lo;
            count_d = cnt_q + 1'b1;
        end else if (accept) begin
            acc_d = tot;
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == OUTPUT && out_ready) begin
            state_d = ACCUM;
            out_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q <= '0;
            cnt_q <= '0;
            out_valid_q <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_valid_q <= out_valid_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            count_q <= count_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_sum = sum_q;
    assign out_ovf = ovf_q;
    assign out_count = count_q;
endmodule

// File: tb/tb_stream_sat_accumulator.sv
// tb_stream_sat_accumulator: directed self-checking bench for stream_sat_accumulator.
module tb_stream_sat_accumulator;
    logic clk = 0, reset = 1, sat_en = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic in_ready, out_valid, out_ovf;
    logic [7:0] in_data = 0, out_sum;
    logic [2:0] out_count;
    int checks = 0, errors = 0;

    stream_sat_accumulator #(.WIDTH(8), .NUM_OPERANDS(5)) dut (
        .clk(clk), .reset(reset), .sat_en(sat_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int d, input bit last, input bit s);
        in_valid = 1; in_data = 8'(d); in_last = last; sat_en = s;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    // sat value only on the final beat; earlier beats carry the opposite value
    task automatic group5(input int a, b, c, d, e, input bit s, input bit last5);
        beat(a, 0, ~s); beat(b, 0, ~s); beat(c, 0, ~s); beat(d, 0, ~s); beat(e, last5, s);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] sum, input bit ovf, input int cnt);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, sum);
        chk({tag, "_ovf"}, out_ovf, ovf);
        chk({tag, "_count"}, out_count, cnt);
        chk({tag, "_rdy"}, in_ready, 0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, "_drained"}, out_valid, 0);
        chk({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_rdy", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_count", out_count, 0);
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("post_rst_rdy", in_ready, 1);

        group5(10, 15, 20, 25, 30, 1, 1);
        expect_out("basic", 8'd100, 0, 5);
        drain("basic");

        group5(100, 100, 100, 100, 100, 1, 1);
        expect_out("satpos", 8'h7F, 1, 5);
        drain("satpos");
        group5(100, 100, 100, 100, 100, 0, 1);
        expect_out("wrap", 8'hF4, 1, 5);
        drain("wrap");

        group5(-100, -100, -100, -100, -100, 1, 1);
        expect_out("satneg", 8'h80, 1, 5);
        drain("satneg");
        group5(127, 127, -128, -128, 0, 1, 1);
        expect_out("edges", 8'hFE, 0, 5);
        drain("edges");

        beat(-5, 0, 1);
        chk("short_nooutput", out_valid, 0);
        beat(3, 1, 1);
        expect_out("short", 8'hFE, 0, 2);
        drain("short");
        group5(1, 1, 1, 1, 1, 1, 0);
        expect_out("cntlimit", 8'd5, 0, 5);

        drain("pre_stall");
        beat(1, 0, 1);
        beat(2, 1, 1);
        expect_out("stall0", 8'd3, 0, 2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 8'(40 + i); in_last = i[0];
            @(posedge clk); #1;
            expect_out($sformatf("stall%0d", i + 1), 8'd3, 0, 2);
        end
        in_valid = 0; in_last = 0;
        drain("stall_hs");

        beat(10, 0, 1); beat(20, 0, 1); beat(30, 0, 1);
        reset = 1;
        #1;
        chk("midrst_rdy", in_ready, 0);
        chk("midrst_valid", out_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        #1;
        beat(1, 0, 1);
        chk("afterrst_nooutput", out_valid, 0);
        beat(2, 1, 1);
        expect_out("afterrst", 8'd3, 0, 2);
        reset = 1;
        #1;
        chk("outrst_valid", out_valid, 0);
        chk("outrst_sum", out_sum, 0);
        chk("outrst_count", out_count, 0);
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("final_rdy", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_sat_accumulator.md
Name: stream_sat_accumulator

Overview:
- Parametrised, sequential successor to the combinational signed five-operand saturating adder.
- Accepts a group of up to NUM_OPERANDS signed WIDTH-bit operands, one per valid/ready beat, and accumulates them at full precision.
- Emits one WIDTH-bit result per group, either saturated or wrapped (runtime mode), plus an overflow flag and an operand count.
- Sits between a streaming operand source and a downstream consumer in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits, two's complement; WIDTH >= 2.
- NUM_OPERANDS, 5, maximum operands per group; NUM_OPERANDS >= 2.
- ACC_W (localparam), WIDTH+$clog2(NUM_OPERANDS)+1, internal accumulator width; no intermediate overflow is possible.
- CNT_W (localparam), $clog2(NUM_OPERANDS+1), width of the operand counter and out_count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sat_en  in  1  1 = saturate result, 0 = wrap; sampled on the group's final accepted beat.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand ready.
- in_data  in  WIDTH  signed operand.
- in_last  in  1  marks the final operand of a short group; qualified by the handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_sum  out  WIDTH  signed result.
- out_ovf  out  1  true sum was outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] (set in both modes).
- out_count  out  CNT_W  number of operands in this group (1..NUM_OPERANDS).

Behaviour:
- Reset (async, any state): state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0. in_ready=0 while reset is high.
- Reset mid-group or mid-output discards the partial sum or pending result. Nothing is emitted.
- in_ready = (state==ACCUM) && !reset, driven combinationally.
- States and transitions:
  - ACCUM: each accepted beat (in_valid && in_ready) sets acc <= acc + sext(in_data) and cnt <= cnt+1.
  - ACCUM -> OUTPUT when an accepted beat has in_last=1 or cnt+1==NUM_OPERANDS. in_last on the NUM_OPERANDS-th beat has the same effect.
  - On that edge: acc and cnt clear to 0; out_sum, out_ovf and out_count are registered from tot = acc + sext(in_data); out_valid <= 1.
  - OUTPUT: in_ready=0. out_sum, out_ovf and out_count hold stable while out_valid && !out_ready.
  - OUTPUT -> ACCUM when out_valid && out_ready; out_valid <= 0 on that edge. The next operand can be accepted in the following cycle.
- Latency: result is visible the cycle after the final beat. Throughput is one group per (count+1) cycles minimum.
- Arithmetic on tot (ACC_W bits, signed):
  - ovf = (tot > 2^(WIDTH-1)-1) || (tot < -2^(WIDTH-1)).
  - sat_en=1: out_sum = MAX if tot > MAX, MIN if tot < MIN, otherwise tot[WIDTH-1:0].
  - sat_en=0: out_sum = tot[WIDTH-1:0] (modulo 2^WIDTH).
- in_valid=0 in ACCUM: no state change. in_data and in_last are ignored when the beat is not accepted.
- sat_en changes between beats have no effect; only the value on the final beat matters.

Test Plan:
- sat_en=1, beats 10,15,20,25,30 (last on 5th) -> one cycle later out_valid=1, out_sum=100, out_ovf=0, out_count=5.
- sat_en=1, five beats of 100 -> out_sum=127, out_ovf=1. Repeat with sat_en=0 -> out_sum=0xF4 (-12), out_ovf=1.
- sat_en=1, five beats of -100 -> out_sum=-128, out_ovf=1. Beats 127,127,-128,-128,0 -> out_sum=-2, out_ovf=0.
- Beats -5 then 3 with in_last=1 -> out_sum=-2, out_count=2, out_ovf=0. Next group 1,1,1,1,1 -> out_sum=5, confirming acc cleared.
- Result pending with out_ready=0 for 3 cycles, in_valid=1 with changing data -> in_ready=0, outputs stable. Handshake on cycle 4 -> next cycle in_ready=1.
- Assert reset after 3 beats (10,20,30), deassert, then send 1,2 with last -> out_sum=3, out_count=2, and no earlier output. Reset during OUTPUT -> out_valid drops to 0 immediately.
